cpu_trace_recorder: RTL and testbench
=====================================

Name: cpu_trace_recorder

Overview:
- Synthesizable trace capture block that sits beside the MIPS CPU core and records per-cycle {PC, instruction, cycle stamp} samples into an on-chip buffer.
- Lets benches and debug logic recover execution history without relying on simulator displays.
- Generalised in address/instruction width, buffer depth and run-length limit, with a PC trigger and two capture modes:
  - fill-once: keep the first DEPTH samples.
  - circular: keep the last DEPTH samples.
- Captured entries are drained oldest-first over a valid/ready read port.

Parameters:
- ADDR_WIDTH, 32, width of sampled PC.
- INSTR_WIDTH, 32, width of sampled instruction.
- DEPTH, 16, buffer entries; power of two, >= 2.
- STAMP_WIDTH, 16, width of cycle counter and per-entry stamp.
- MAX_CYCLES, 130, cycles after start at which recording auto-stops; 0 disables the limit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms/starts a run (ignored unless IDLE).
- stop  in  1  one-cycle pulse; ends recording (ARMED or RECORD -> DONE).
- mode  in  1  0 = fill-once, 1 = circular; sampled at start.
- trig_en  in  1  1 = wait for trig_pc before recording; sampled at start.
- trig_pc  in  ADDR_WIDTH  trigger PC value; sampled at start.
- sample_valid  in  1  PC/instr inputs hold a retiring instruction this cycle.
- pc  in  ADDR_WIDTH  current program counter.
- instr  in  INSTR_WIDTH  current instruction word.
- filter_opcode  in  6  opcode filter value; see Optional Feature.
- rd_ready  in  1  consumer accepts the read entry.
- rd_valid  out  1  read entry valid.
- rd_pc  out  ADDR_WIDTH  PC of oldest entry.
- rd_instr  out  INSTR_WIDTH  instruction of oldest entry.
- rd_stamp  out  STAMP_WIDTH  cycle stamp of oldest entry.
- count  out  clog2(DEPTH)+1  entries currently held.
- overflow  out  1  circular mode overwrote at least one entry this run.
- busy  out  1  state is ARMED or RECORD.
- done  out  1  state is DONE.

Behaviour:
- Reset: state IDLE. count=0, rd/wr pointers=0, cycle counter=0, overflow=0, rd_valid=0, rd_pc/rd_instr/rd_stamp=0, busy=0, done=0. Reset mid-run discards all captured data.
- Cycle counter:
  - Cleared on the accepted start.
  - Increments every cycle in ARMED and RECORD; saturates at all-ones.
  - Its pre-increment value is the stamp written with each entry.
  - When MAX_CYCLES != 0 and the counter equals MAX_CYCLES-1, the state moves to DONE next cycle.
- States:
  - IDLE: on start, latch mode/trig_en/trig_pc, clear count, pointers and overflow; go to ARMED if trig_en, else RECORD.
  - ARMED: when sample_valid && pc == trig_pc, write that sample and go to RECORD. Nothing is written before the trigger.
  - RECORD: write every sample_valid cycle.
    - Fill-once: when count reaches DEPTH, go to DONE; the sample that fills the last slot is kept.
    - Circular: when full, overwrite the oldest entry (advance rd pointer with wr pointer, count stays DEPTH) and set overflow.
  - DONE: rd_valid = (count != 0). On rd_valid && rd_ready, pop: rd pointer +1 mod DEPTH, count -1. When the final entry pops, go to IDLE; done clears and overflow is held until the next start.
- Precedence:
  - Same-cycle stop and write: the write happens, then DONE.
  - stop takes effect together with the cycle limit.
  - start outside IDLE is ignored.
  - DONE with count=0 (e.g. stop while ARMED): go to IDLE next cycle.
- Read data: rd_* show the oldest entry combinationally from the buffer whenever rd_valid=1, and are 0 otherwise. There is no read during capture.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: TRACE_OPCODE_FILTER_EN.
- Defined: a sample is written only if instr[31:26] == filter_opcode, in addition to sample_valid. The trigger match is unaffected by the filter. The cycle stamp still counts every cycle.
- Undefined: filter_opcode is ignored and every sample_valid cycle is recorded.

Test Plan:
- Fill-once, no trigger, DEPTH=16: start, then 20 cycles of pc=0,4,8,...
  -> DONE after the 16th sample, count=16.
  -> Drain returns pc 0..60 with stamps 0..15; overflow=0; IDLE after the last pop.
- Circular, DEPTH=16, MAX_CYCLES=130: start with pc incrementing by 4 every cycle.
  -> Auto-stop at stamp 129; overflow=1.
  -> Drain yields stamps 114..129, pc 456..516, oldest first.
- Trigger: trig_en=1, trig_pc=0x20, pc counts 0x0,0x4,...
  -> First entry is pc=0x20, stamp=8; no earlier entries.
- Handshake: in DONE with count=4, hold rd_ready low for 3 cycles, then toggle it.
  -> rd_* stable while stalled; exactly 4 pops; rd_valid falls after the 4th.
- Reset mid-RECORD after 5 samples
  -> Next cycle: IDLE, count=0, rd_valid=0, busy=0.
- With TRACE_OPCODE_FILTER_EN, filter_opcode=6'b100011, instructions alternating lw/add for 10 samples
  -> count=5, all rd_instr[31:26]=100011.

Source files
------------

// File: rtl/cpu_trace_recorder.sv
// cpu_trace_recorder: captures {PC, instruction, cycle stamp} samples from the
// CPU retire stream into a DEPTH-entry buffer. There are two capture modes:
// fill-once keeps the first DEPTH samples, circular keeps the last DEPTH.
// Recording can optionally wait for a trigger PC. Once recording ends, the
// captured entries are drained oldest-first over a valid/ready port.
//
// Build option: define TRACE_OPCODE_FILTER_EN to record only samples whose
// instr[31:26] equals filter_opcode. Without it, filter_opcode is ignored.
//
// state  | meaning
// IDLE   | waiting for start; a drained buffer keeps its overflow flag
// ARMED  | run started, waiting for sample_valid with pc == trig_pc
// RECORD | writing every qualifying sample
// DONE   | capture finished; entries drain over the rd_* port
module cpu_trace_recorder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 16,
  parameter int STAMP_WIDTH = 16,
  parameter int MAX_CYCLES  = 130
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      mode,
  input  logic                      trig_en,
  input  logic [ADDR_WIDTH-1:0]     trig_pc,
  input  logic                      sample_valid,
  input  logic [ADDR_WIDTH-1:0]     pc,
  input  logic [INSTR_WIDTH-1:0]    instr,
  input  logic [5:0]                filter_opcode,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [ADDR_WIDTH-1:0]     rd_pc,
  output logic [INSTR_WIDTH-1:0]    rd_instr,
  output logic [STAMP_WIDTH-1:0]    rd_stamp,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      busy,
  output logic                      done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]       LAST_CNT   = CNT_W'(DEPTH - 1);
  localparam logic [STAMP_WIDTH-1:0] LIMIT_STMP = STAMP_WIDTH'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECORD, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic                    mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   trig_pc_q, trig_pc_d;
  logic [STAMP_WIDTH-1:0]  cyc_q, cyc_d;

  logic [ADDR_WIDTH-1:0]   mem_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0]  mem_instr [DEPTH];
  logic [STAMP_WIDTH-1:0]  mem_stamp [DEPTH];

  logic filter_ok;
  logic trig_hit;
  logic wr_ok;
  logic full;
  logic limit_hit;
  logic pop;

`ifdef TRACE_OPCODE_FILTER_EN
  assign filter_ok = (instr[31:26] == filter_opcode);
`else
  logic unused_filter;
  assign unused_filter = ^filter_opcode;
  assign filter_ok     = 1'b1;
`endif

  // The trigger match ignores the opcode filter. Only the write is filtered.
  assign trig_hit  = (state_q == S_ARMED) && sample_valid && (pc == trig_pc_q);
  assign full      = (count_q == FULL_CNT);
  // Fill-once never writes into a full buffer; circular overwrites the oldest entry.
  assign wr_ok     = sample_valid && filter_ok &&
                     ((state_q == S_RECORD) || trig_hit) &&
                     !(full && !mode_q);
  assign limit_hit = (MAX_CYCLES != 0) && (cyc_q == LIMIT_STMP);
  assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
  assign pop       = rd_valid && rd_ready;

  // Oldest entry is presented combinationally, and forced to zero when not valid.
  assign rd_pc    = rd_valid ? mem_pc[rd_ptr_q]    : '0;
  assign rd_instr = rd_valid ? mem_instr[rd_ptr_q] : '0;
  assign rd_stamp = rd_valid ? mem_stamp[rd_ptr_q] : '0;

  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == S_ARMED) || (state_q == S_RECORD);
  assign done     = (state_q == S_DONE);

  // Next-state and datapath update for the capture/drain sequencer.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mode_d     = mode_q;
    trig_pc_d  = trig_pc_q;
    cyc_d      = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          trig_pc_d  = trig_pc;
          count_d    = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          overflow_d = 1'b0;
          cyc_d      = '0;
          state_d    = trig_en ? S_ARMED : S_RECORD;
        end
      end
      S_ARMED, S_RECORD: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (wr_ok) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (full) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        if (trig_hit) state_d = S_RECORD;
        if (!mode_q && wr_ok && (count_q == LAST_CNT)) state_d = S_DONE;
        if (stop || limit_hit) state_d = S_DONE;
      end
      S_DONE: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end else if (pop) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
          if (count_q == CNT_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mode_q     <= 1'b0;
      trig_pc_q  <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mode_q     <= mode_d;
      trig_pc_q  <= trig_pc_d;
      cyc_q      <= cyc_d;
    end
  end

  // Trace buffer write. The stamp is the cycle count before it increments.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_pc[wr_ptr_q]    <= pc;
      mem_instr[wr_ptr_q] <= instr;
      mem_stamp[wr_ptr_q] <= cyc_q;
    end
  end

endmodule

// File: tb/tb_cpu_trace_recorder.sv
// Directed testbench for cpu_trace_recorder with default parameters
// (32-bit PC/instr, DEPTH=16, 16-bit stamp, MAX_CYCLES=130).
module tb_cpu_trace_recorder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        sample_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic [5:0]  filter_opcode = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_instr;
  logic [15:0] rd_stamp;
  logic [4:0]  count;
  logic        overflow;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  cpu_trace_recorder dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .trig_en(trig_en), .trig_pc(trig_pc), .sample_valid(sample_valid),
    .pc(pc), .instr(instr), .filter_opcode(filter_opcode),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc),
    .rd_instr(rd_instr), .rd_stamp(rd_stamp), .count(count),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic m, input logic te, input logic [31:0] tp);
    mode = m; trig_en = te; trig_pc = tp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || rd_pc !== 32'd0 || rd_instr !== 32'd0 || rd_stamp !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%b cnt=%0d ovf=%b busy=%b done=%b pc=%h expected all zero",
               rd_valid, count, overflow, busy, done, rd_pc);
    end
  endtask

  task automatic test_fill_once();
    pulse_start(1'b0, 1'b0, 32'd0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL fill_busy: got %b expected 1", busy); end
    sample_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pc = 32'(4 * i); instr = 32'h1000_0000 + 32'(i);
      tick();
      if (i == 14) begin
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL fill_early_done: got %b expected 0", done); end
      end
      if (i == 15) begin
        total++;
        if (done !== 1'b1 || count !== 5'd16) begin
          bad++; $display("FAIL fill_done16: got done=%b cnt=%0d expected 1/16", done, count);
        end
      end
    end
    sample_valid = 1'b0;
    total++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      bad++; $display("FAIL fill_hold: got cnt=%0d ovf=%b expected 16/0", count, overflow);
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'(4 * k) || rd_stamp !== 16'(k) ||
          rd_instr !== 32'h1000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL fill_drain[%0d]: got v=%b pc=%0d st=%0d in=%h expected 1/%0d/%0d/%h",
                 k, rd_valid, rd_pc, rd_stamp, rd_instr, 4 * k, k, 32'h1000_0000 + 32'(k));
      end
      tick();
    end
    rd_ready = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL fill_idle: got done=%b busy=%b v=%b cnt=%0d expected 0/0/0/0",
                      done, busy, rd_valid, count);
    end
  endtask

  task automatic test_circular();
    int stop_at;
    stop_at = -1;
    pulse_start(1'b1, 1'b0, 32'd0);
    sample_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      pc = 32'(4 * i); instr = 32'hC000_0000 + 32'(i);
      tick();
      if (done === 1'b1) begin stop_at = i; break; end
    end
    sample_valid = 1'b0;
    total++;
    if (stop_at !== 129) begin bad++; $display("FAIL circ_limit: got stop at %0d expected 129", stop_at); end
    total++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      bad++; $display("FAIL circ_state: got ovf=%b cnt=%0d expected 1/16", overflow, count);
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_stamp !== 16'(114 + k) || rd_pc !== 32'(4 * (114 + k))) begin
        bad++; $display("FAIL circ_drain[%0d]: got v=%b st=%0d pc=%0d expected 1/%0d/%0d",
                        k, rd_valid, rd_stamp, rd_pc, 114 + k, 4 * (114 + k));
      end
      tick();
    end
    rd_ready = 1'b0;
    total++;
    if (done !== 1'b0 || overflow !== 1'b1) begin
      bad++; $display("FAIL circ_idle: got done=%b ovf=%b expected 0/1", done, overflow);
    end
  endtask

  task automatic test_trigger();
    pulse_start(1'b0, 1'b1, 32'h20);
    sample_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      pc = 32'(4 * i); instr = 32'hA000_0000 + 32'(i);
      if (i == 10) stop = 1'b1;
      tick();
      if (i == 7) begin
        total++;
        if (count !== 5'd0 || busy !== 1'b1) begin
          bad++; $display("FAIL trig_pre: got cnt=%0d busy=%b expected 0/1", count, busy);
        end
      end
    end
    stop = 1'b0; sample_valid = 1'b0;
    total++;
    if (done !== 1'b1 || count !== 5'd3) begin
      bad++; $display("FAIL trig_stop_write: got done=%b cnt=%0d expected 1/3", done, count);
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'h20 + 32'(4 * k) || rd_stamp !== 16'(8 + k)) begin
        bad++; $display("FAIL trig_drain[%0d]: got v=%b pc=%h st=%0d expected 1/%h/%0d",
                        k, rd_valid, rd_pc, rd_stamp, 32'h20 + 32'(4 * k), 8 + k);
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_handshake();
    logic [31:0] held;
    int pops;
    pops = 0;
    pulse_start(1'b0, 1'b0, 32'd0);
    sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h100 + 32'(4 * i); instr = 32'h5000_0000 + 32'(i);
      start = (i == 2);
      stop = (i == 3);
      tick();
    end
    start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    total++;
    if (done !== 1'b1 || count !== 5'd4) begin
      bad++; $display("FAIL hs_setup: got done=%b cnt=%0d expected 1/4", done, count);
    end
    held = rd_pc;
    for (int s = 0; s < 3; s++) begin
      tick();
      total++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'h100 || rd_pc !== held || count !== 5'd4) begin
        bad++; $display("FAIL hs_stall[%0d]: got v=%b pc=%h cnt=%0d expected 1/100/4",
                        s, rd_valid, rd_pc, count);
      end
    end
    for (int c = 0; c < 20 && rd_valid === 1'b1; c++) begin
      rd_ready = c[0];
      #1;
      if (rd_ready) begin
        total++;
        if (rd_pc !== 32'h100 + 32'(4 * pops) || rd_stamp !== 16'(pops)) begin
          bad++; $display("FAIL hs_pop[%0d]: got pc=%h st=%0d expected %h/%0d",
                          pops, rd_pc, rd_stamp, 32'h100 + 32'(4 * pops), pops);
        end
        pops++;
      end
      tick();
    end
    rd_ready = 1'b0;
    total++;
    if (pops !== 4 || rd_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL hs_count: got pops=%0d v=%b done=%b expected 4/0/0", pops, rd_valid, done);
    end
  endtask

  task automatic test_stop_armed();
    pulse_start(1'b0, 1'b1, 32'hFFFC);
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin pc = 32'(4 * i); tick(); end
    stop = 1'b1;
    tick();
    stop = 1'b0; sample_valid = 1'b0;
    total++;
    if (done !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL armed_stop: got done=%b cnt=%0d v=%b expected 1/0/0", done, count, rd_valid);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL armed_idle: got done=%b busy=%b expected 0/0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(1'b0, 1'b0, 32'd0);
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin pc = 32'(4 * i); tick(); end
    total++;
    if (count !== 5'd5) begin bad++; $display("FAIL mid_count: got %0d expected 5", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0; sample_valid = 1'b0;
    total++;
    if (count !== 5'd0 || rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got cnt=%0d v=%b busy=%b done=%b expected 0/0/0/0",
                      count, rd_valid, busy, done);
    end
  endtask

  task automatic test_filter();
    int exp_n;
`ifdef TRACE_OPCODE_FILTER_EN
    exp_n = 5;
`else
    exp_n = 10;
`endif
    filter_opcode = 6'b100011;
    pulse_start(1'b0, 1'b0, 32'd0);
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc = 32'(4 * i);
      instr = i[0] ? 32'h0122_4020 : (32'h8C00_0000 + 32'(i));
      stop = (i == 9);
      tick();
    end
    stop = 1'b0; sample_valid = 1'b0;
    total++;
    if (count !== 5'(exp_n)) begin bad++; $display("FAIL filt_count: got %0d expected %0d", count, exp_n); end
    rd_ready = 1'b1;
    for (int k = 0; k < exp_n; k++) begin
      total++;
`ifdef TRACE_OPCODE_FILTER_EN
      if (rd_valid !== 1'b1 || rd_instr[31:26] !== 6'b100011) begin
        bad++; $display("FAIL filt_op[%0d]: got v=%b op=%b expected 1/100011", k, rd_valid, rd_instr[31:26]);
      end
`else
      if (rd_valid !== 1'b1 || rd_pc !== 32'(4 * k)) begin
        bad++; $display("FAIL filt_off[%0d]: got v=%b pc=%0d expected 1/%0d", k, rd_valid, rd_pc, 4 * k);
      end
`endif
      tick();
    end
    rd_ready = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL filt_idle: got v=%b done=%b expected 0/0", rd_valid, done);
    end
  endtask

  initial begin
    test_reset();
    test_fill_once();
    test_circular();
    test_trigger();
    test_handshake();
    test_stop_armed();
    test_reset_mid();
    test_filter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
